alu_secuencial: RTL and testbench

Parametrised, multi-cycle successor to the combinational ALU for the CPU datapath.
- Single-cycle logic and add/sub ops complete in one cycle.
- MUL uses an iterative shift-add unit; DIV and MOD use a restoring divider.
- Operands are captured on a start/busy/done handshake.
- Result and C/S/O/Z flags are registered and held until the next accepted operation. The control unit stalls on busy.

---
 rtl/alu_secuencial_if.sv | 39 +++
 rtl/alu_secuencial.sv | 198 +++++++++++++++++++
 tb/tb_alu_secuencial.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_secuencial_if.sv
// alu_secuencial_if: start/busy/done handshake bundle between the control
// unit and the sequential ALU.
//   start      - request, honoured only while busy is low
//   opcode     - operation selector, captured together with start
//   operando_a - operand A, captured together with start
//   operando_b - operand B, captured together with start
//   busy       - multi-cycle operation in progress
//   done       - one-cycle pulse, result and flags valid from this cycle
//   resultado  - registered result
//   C, S, O, Z - carry/borrow/high-part, sign, overflow, zero flags
//   error      - unsupported opcode or divide-by-zero
// modport master drives the request side, modport slave is the ALU.
interface alu_secuencial_if #(
  parameter int BITS_DATA   = 32,
  parameter int BITS_OPCODE = 5
);
  logic                   start;
  logic [BITS_OPCODE-1:0] opcode;
  logic [BITS_DATA-1:0]   operando_a;
  logic [BITS_DATA-1:0]   operando_b;
  logic                   busy;
  logic                   done;
  logic [BITS_DATA-1:0]   resultado;
  logic                   C;
  logic                   S;
  logic                   O;
  logic                   Z;
  logic                   error;

  modport master (
    output start, opcode, operando_a, operando_b,
    input  busy, done, resultado, C, S, O, Z, error
  );

  modport slave (
    input  start, opcode, operando_a, operando_b,
    output busy, done, resultado, C, S, O, Z, error
  );
endinterface

// File: rtl/alu_secuencial.sv
// alu_secuencial: multi-cycle ALU for the CPU datapath.
// Logic, ADD/SUB, NEG, NOT, NOP and HLT finish one cycle after start;
// MUL (shift-add) and DIV/MOD (restoring divider) take BITS_DATA iterations.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - alu_secuencial_if.slave handshake, operands, result and flags
module alu_secuencial #(
  parameter int BITS_DATA   = 32,
  parameter int BITS_OPCODE = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_secuencial_if.slave     bus
);

  localparam logic [BITS_OPCODE-1:0] OP_NOP = BITS_OPCODE'(0);
  localparam logic [BITS_OPCODE-1:0] OP_ADD = BITS_OPCODE'(1);
  localparam logic [BITS_OPCODE-1:0] OP_SUB = BITS_OPCODE'(2);
  localparam logic [BITS_OPCODE-1:0] OP_AND = BITS_OPCODE'(3);
  localparam logic [BITS_OPCODE-1:0] OP_OR  = BITS_OPCODE'(4);
  localparam logic [BITS_OPCODE-1:0] OP_XOR = BITS_OPCODE'(5);
  localparam logic [BITS_OPCODE-1:0] OP_NOT = BITS_OPCODE'(6);
  localparam logic [BITS_OPCODE-1:0] OP_NEG = BITS_OPCODE'(7);
  localparam logic [BITS_OPCODE-1:0] OP_MUL = BITS_OPCODE'(8);
  localparam logic [BITS_OPCODE-1:0] OP_DIV = BITS_OPCODE'(9);
  localparam logic [BITS_OPCODE-1:0] OP_MOD = BITS_OPCODE'(10);
  localparam logic [BITS_OPCODE-1:0] OP_HLT = BITS_OPCODE'(31);

  localparam int MSB = BITS_DATA - 1;
  localparam int CW  = $clog2(BITS_DATA + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t                 state;
  logic [BITS_OPCODE-1:0] op_r;
  logic [BITS_DATA-1:0]   a_r, b_r;
  logic [BITS_DATA-1:0]   reg_hi, reg_lo;
  logic [CW-1:0]          count;
  logic                   busy_r, done_r, err_r, c_r, s_r, o_r, z_r;
  logic [BITS_DATA-1:0]   res_r;

  logic                   accept, is_iter, b_zero_in;
  logic [BITS_DATA:0]     mul_sum, div_shift, add_full, sub_full;
  logic [BITS_DATA-1:0]   div_diff, neg_res, res_n;
  logic                   div_ge, c_n, o_n, err_n, upd;

  // Requests are taken whenever no multi-cycle op is running, which includes
  // the FIN cycle of a single-cycle op so back-to-back ops issue every cycle.
  // Division by zero skips the iterative unit entirely.
  always_comb begin
    accept    = bus.start && !busy_r;
    b_zero_in = (bus.operando_b == '0);
    is_iter   = (bus.opcode == OP_MUL) ||
                (((bus.opcode == OP_DIV) || (bus.opcode == OP_MOD)) && !b_zero_in);
  end

  // Datapath for one iteration. MUL keeps {product_high, multiplier} in
  // {reg_hi, reg_lo}; DIV/MOD keeps {remainder, dividend/quotient}.
  // The trial subtraction is done on BITS_DATA bits: whenever it is used the
  // true difference is below B and therefore fits.
  always_comb begin
    mul_sum   = {1'b0, reg_hi} + (reg_lo[0] ? {1'b0, a_r} : '0);
    div_shift = {reg_hi, reg_lo[MSB]};
    div_ge    = (div_shift >= {1'b0, b_r});
    div_diff  = div_shift[MSB:0] - b_r;
  end

  // Final result and flags for the op held in op_r, consumed in FIN.
  always_comb begin
    add_full = {1'b0, a_r} + {1'b0, b_r};
    sub_full = {1'b0, a_r} - {1'b0, b_r};
    neg_res  = '0 - a_r;
    res_n    = '0;
    c_n      = 1'b0;
    o_n      = 1'b0;
    err_n    = 1'b0;
    upd      = 1'b1;
    case (op_r)
      OP_NOP, OP_HLT: upd = 1'b0;
      OP_ADD: begin
        res_n = add_full[MSB:0];
        c_n   = add_full[BITS_DATA];
        o_n   = (a_r[MSB] == b_r[MSB]) && (add_full[MSB] != a_r[MSB]);
      end
      OP_SUB: begin
        res_n = sub_full[MSB:0];
        c_n   = sub_full[BITS_DATA];
        o_n   = (a_r[MSB] != b_r[MSB]) && (sub_full[MSB] != a_r[MSB]);
      end
      OP_AND: res_n = a_r & b_r;
      OP_OR:  res_n = a_r | b_r;
      OP_XOR: res_n = a_r ^ b_r;
      OP_NOT: res_n = ~a_r;
      OP_NEG: begin
        res_n = neg_res;
        // Only the most negative value negates to itself.
        o_n   = a_r[MSB] && neg_res[MSB];
      end
      OP_MUL: begin
        res_n = reg_lo;
        c_n   = |reg_hi;
        o_n   = |reg_hi;
      end
      OP_DIV: begin
        if (b_r == '0) begin
          res_n = '1;
          o_n   = 1'b1;
          err_n = 1'b1;
        end else begin
          res_n = reg_lo;
        end
      end
      OP_MOD: begin
        if (b_r == '0) begin
          res_n = a_r;
          o_n   = 1'b1;
          err_n = 1'b1;
        end else begin
          res_n = reg_hi;
        end
      end
      default: err_n = 1'b1;
    endcase
  end

  // Control FSM. A new capture is applied after the per-state work so that
  // an op accepted in FIN overrides the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      reg_hi <= '0;
      reg_lo <= '0;
      count  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      res_r  <= '0;
      c_r    <= 1'b0;
      s_r    <= 1'b0;
      o_r    <= 1'b0;
      z_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: ;
        CALC: begin
          if (op_r == OP_MUL) begin
            {reg_hi, reg_lo} <= {mul_sum, reg_lo[MSB:1]};
          end else begin
            reg_hi <= div_ge ? div_diff : div_shift[MSB:0];
            reg_lo <= {reg_lo[MSB-1:0], div_ge};
          end
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIN;
        end
        FIN: begin
          if (upd) begin
            res_r <= res_n;
            c_r   <= c_n;
            o_r   <= o_n;
            s_r   <= res_n[MSB];
            z_r   <= (res_n == '0);
          end
          err_r  <= err_n;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        op_r   <= bus.opcode;
        a_r    <= bus.operando_a;
        b_r    <= bus.operando_b;
        reg_hi <= '0;
        reg_lo <= (bus.opcode == OP_MUL) ? bus.operando_b : bus.operando_a;
        count  <= CW'(BITS_DATA);
        busy_r <= is_iter;
        state  <= is_iter ? CALC : FIN;
      end
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.resultado = res_r;
  assign bus.C         = c_r;
  assign bus.S         = s_r;
  assign bus.O         = o_r;
  assign bus.Z         = z_r;
  assign bus.error     = err_r;

endmodule

// File: tb/tb_alu_secuencial.sv
// tb_alu_secuencial: directed, self-checking bench for alu_secuencial.
// Flags are compared as the packed word {C,S,O,Z,error}.
module tb_alu_secuencial;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;
  localparam logic [4:0] OP_NOT = 5'd6;
  localparam logic [4:0] OP_NEG = 5'd7;
  localparam logic [4:0] OP_MUL = 5'd8;
  localparam logic [4:0] OP_DIV = 5'd9;
  localparam logic [4:0] OP_MOD = 5'd10;
  localparam logic [4:0] OP_HLT = 5'd31;
  localparam logic [4:0] OP_BAD = 5'd20;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flags;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alu_secuencial_if #(.BITS_DATA(32), .BITS_OPCODE(5)) bus ();

  alu_secuencial #(.BITS_DATA(32), .BITS_OPCODE(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and wait for done. lat is the number of rising edges from
  // the accepting edge to the edge that raised done (-1 if it never came).
  // Inputs are scrambled right after acceptance to show they are captured.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic [4:0] flg);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.opcode     = op;
    bus.operando_a = a;
    bus.operando_b = b;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.opcode     = OP_SUB;
    bus.operando_a = $urandom;
    bus.operando_b = $urandom;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.done && lat < 100);
    if (!bus.done) lat = -1;
    res = bus.resultado;
    flg = {bus.C, bus.S, bus.O, bus.Z, bus.error};
  endtask

  task automatic test_reset();
    int          lat;
    int          pulses;
    logic [31:0] res;
    logic [4:0]  flg;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.resultado, bus.C, bus.S, bus.O, bus.Z, bus.error} !== 38'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b res=%h flags=%b expected all zero",
               bus.busy, bus.done, bus.resultado, {bus.C, bus.S, bus.O, bus.Z, bus.error});
    end
    rst_n = 1'b1;

    @(negedge clk);
    bus.start      = 1'b1;
    bus.opcode     = OP_MUL;
    bus.operando_a = 32'h0001_0000;
    bus.operando_b = 32'h0001_0003;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.resultado, bus.C, bus.S, bus.O, bus.Z, bus.error} !== 38'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_mul: got busy=%b done=%b res=%h expected all zero",
               bus.busy, bus.done, bus.resultado);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("[TB] FAIL abandoned_mul_done: got %0d pulses expected 0", pulses);
    end
    vectors++;
    if ({bus.busy, bus.resultado} !== 33'd0) begin
      miscompares++;
      $display("[TB] FAIL after_reset_idle: got busy=%b res=%h expected 0", bus.busy, bus.resultado);
    end

    run_op(OP_ADD, 32'd2, 32'd3, lat, res, flg);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("[TB] FAIL add_after_reset latency: got %0d expected 1", lat);
    end
    vectors++;
    if (res !== 32'd5) begin
      miscompares++;
      $display("[TB] FAIL add_after_reset result: got %h expected 00000005", res);
    end
  endtask

  task automatic test_single_cycle();
    vec_t        tbl[$];
    int          lat;
    logic [31:0] res;
    logic [4:0]  flg;
    tbl.push_back('{"add_ovf",   OP_ADD, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 5'b01100, 1});
    tbl.push_back('{"add_carry", OP_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0,         5'b10010, 1});
    tbl.push_back('{"sub_borrow",OP_SUB, 32'd3,         32'd5,         32'hFFFF_FFFE, 5'b11000, 1});
    tbl.push_back('{"sub_ovf",   OP_SUB, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 5'b00100, 1});
    tbl.push_back('{"not",       OP_NOT, 32'h0F0F_0F0F, 32'h0,         32'hF0F0_F0F0, 5'b01000, 1});
    tbl.push_back('{"neg_min",   OP_NEG, 32'h8000_0000, 32'h0,         32'h8000_0000, 5'b01100, 1});
    tbl.push_back('{"neg_5",     OP_NEG, 32'd5,         32'h0,         32'hFFFF_FFFB, 5'b01000, 1});
    tbl.push_back('{"nop_hold",  OP_NOP, 32'h1234,      32'h5678,      32'hFFFF_FFFB, 5'b01000, 1});
    tbl.push_back('{"hlt_hold",  OP_HLT, 32'h0,         32'h0,         32'hFFFF_FFFB, 5'b01000, 1});
    tbl.push_back('{"invalid",   OP_BAD, 32'h55,        32'hAA,        32'h0,         5'b00011, 1});
    tbl.push_back('{"xor",       OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 5'b01000, 1});
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, res, flg);
      vectors++;
      if (lat !== tbl[i].lat) begin
        miscompares++;
        $display("[TB] FAIL %s latency: got %0d expected %0d", tbl[i].name, lat, tbl[i].lat);
      end
      vectors++;
      if (res !== tbl[i].res) begin
        miscompares++;
        $display("[TB] FAIL %s result: got %h expected %h", tbl[i].name, res, tbl[i].res);
      end
      vectors++;
      if (flg !== tbl[i].flags) begin
        miscompares++;
        $display("[TB] FAIL %s flags CSOZE: got %b expected %b", tbl[i].name, flg, tbl[i].flags);
      end
    end
  endtask

  task automatic test_mul();
    int          cyc;
    int          lat;
    logic [31:0] res;
    logic [4:0]  flg;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.opcode     = OP_MUL;
    bus.operando_a = 32'h0001_0000;
    bus.operando_b = 32'h0001_0000;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 5) begin
        bus.start      = 1'b1;
        bus.opcode     = OP_ADD;
        bus.operando_a = 32'd1;
        bus.operando_b = 32'd1;
      end
      if (cyc == 6) bus.start = 1'b0;
    end while (!bus.done && cyc < 100);
    vectors++;
    if (cyc !== 33) begin
      miscompares++;
      $display("[TB] FAIL mul_big latency: got %0d expected 33", cyc);
    end
    vectors++;
    if (bus.resultado !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL mul_big result: got %h expected 00000000", bus.resultado);
    end
    vectors++;
    if ({bus.C, bus.S, bus.O, bus.Z, bus.error} !== 5'b10110) begin
      miscompares++;
      $display("[TB] FAIL mul_big flags CSOZE: got %b expected 10110",
               {bus.C, bus.S, bus.O, bus.Z, bus.error});
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.done, bus.resultado} !== 33'd0) begin
      miscompares++;
      $display("[TB] FAIL mul_ignored_start: got done=%b res=%h expected 0/00000000",
               bus.done, bus.resultado);
    end

    run_op(OP_MUL, 32'd1234, 32'd5678, lat, res, flg);
    vectors++;
    if ({lat[7:0], res, flg} !== {8'd33, 32'd7006652, 5'b00000}) begin
      miscompares++;
      $display("[TB] FAIL mul_small: got lat=%0d res=%0d flags=%b expected 33/7006652/00000",
               lat, res, flg);
    end
  endtask

  task automatic test_div();
    vec_t        tbl[$];
    int          lat;
    logic [31:0] res;
    logic [4:0]  flg;
    tbl.push_back('{"div_100_7",  OP_DIV, 32'd100,       32'd7,  32'd14,        5'b00000, 33});
    tbl.push_back('{"mod_100_7",  OP_MOD, 32'd100,       32'd7,  32'd2,         5'b00000, 33});
    tbl.push_back('{"div_by_0",   OP_DIV, 32'd9,         32'd0,  32'hFFFF_FFFF, 5'b01101, 1});
    tbl.push_back('{"mod_by_0",   OP_MOD, 32'd9,         32'd0,  32'd9,         5'b00101, 1});
    tbl.push_back('{"div_max_3",  OP_DIV, 32'hFFFF_FFFF, 32'd3,  32'h5555_5555, 5'b00000, 33});
    tbl.push_back('{"mod_max_10", OP_MOD, 32'hFFFF_FFFF, 32'd10, 32'd5,         5'b00000, 33});
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, res, flg);
      vectors++;
      if (lat !== tbl[i].lat) begin
        miscompares++;
        $display("[TB] FAIL %s latency: got %0d expected %0d", tbl[i].name, lat, tbl[i].lat);
      end
      vectors++;
      if (res !== tbl[i].res) begin
        miscompares++;
        $display("[TB] FAIL %s result: got %h expected %h", tbl[i].name, res, tbl[i].res);
      end
      vectors++;
      if (flg !== tbl[i].flags) begin
        miscompares++;
        $display("[TB] FAIL %s flags CSOZE: got %b expected %b", tbl[i].name, flg, tbl[i].flags);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.start      = 1'b1;
    bus.opcode     = OP_AND;
    bus.operando_a = 32'hFF00_FF00;
    bus.operando_b = 32'h0FF0_0FF0;
    @(posedge clk);
    #1;
    bus.opcode     = OP_OR;
    bus.operando_a = 32'hFF00_FF00;
    bus.operando_b = 32'h00F0_00F0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    vectors++;
    if ({bus.done, bus.resultado} !== {1'b1, 32'h0F00_0F00}) begin
      miscompares++;
      $display("[TB] FAIL b2b_and: got done=%b res=%h expected 1/0f000f00", bus.done, bus.resultado);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.done, bus.resultado, bus.S} !== {1'b1, 32'hFFF0_FFF0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL b2b_or: got done=%b res=%h S=%b expected 1/fff0fff0/1",
               bus.done, bus.resultado, bus.S);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_done_drop: got %b expected 0", bus.done);
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    bus.start      = 1'b0;
    bus.opcode     = '0;
    bus.operando_a = '0;
    bus.operando_b = '0;
    $display("[TB] alu_secuencial directed test start");
    test_reset();
    test_single_cycle();
    test_mul();
    test_div();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
